// File: rtl/fifo_read_drainer_if.sv
// FIFO read port, drain command/status and downstream stream
// bundled for the read-side drainer.
interface fifo_read_drainer_if #(
    parameter int DSIZE = 8,
    parameter int LSIZE = 8,
    parameter int CSIZE = 16
);
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             start;
    logic [LSIZE-1:0] len;
    logic             abort;
    logic             busy;
    logic             done;
    logic [DSIZE-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic [CSIZE-1:0] count;

    modport slave (
        input  rdata, rempty, start, len, abort, m_ready,
        output rinc, busy, done, m_data, m_valid, count
    );

    modport master (
        output rdata, rempty, start, len, abort, m_ready,
        input  rinc, busy, done, m_data, m_valid, count
    );
endinterface

// File: rtl/fifo_read_drainer.sv
// Read-domain drainer: pops a commanded number of words from the
// async FIFO into a 2-entry buffer and streams them downstream.
module fifo_read_drainer #(
    parameter int DSIZE = 8,
    parameter int LSIZE = 8,
    parameter int CSIZE = 16
) (
    input  logic               rclk,
    input  logic               rrst_n,
    fifo_read_drainer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [LSIZE-1:0] r_remain;
    logic [DSIZE-1:0] r_buf0;
    logic [DSIZE-1:0] r_buf1;
    logic             r_head;
    logic [1:0]       r_occ;
    logic [CSIZE-1:0] r_count;
    logic             r_busy;
    logic             r_done;

    logic             w_rinc;
    logic             w_pop;
    logic             w_tail;
    logic [1:0]       w_occ_nxt;

    // Abort masks the pop in the same cycle it is seen.
    assign w_rinc = (r_state == S_RUN) && !bus.rempty &&
                    (r_remain != '0) && (r_occ != 2'd2) &&
                    !bus.abort;
    assign w_pop     = (r_occ != 2'd0) && bus.m_ready;
    assign w_tail    = r_head ^ r_occ[0];
    assign w_occ_nxt = r_occ + {1'b0, w_rinc} - {1'b0, w_pop};

    assign bus.rinc    = w_rinc;
    assign bus.m_valid = (r_occ != 2'd0);
    assign bus.m_data  = r_head ? r_buf1 : r_buf0;
    assign bus.count   = r_count;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_head  <= 1'b0;
            r_occ   <= 2'd0;
            r_count <= '0;
        end else begin
            if (w_rinc) begin
                if (w_tail) r_buf1 <= bus.rdata;
                else        r_buf0 <= bus.rdata;
                r_count <= r_count + 1'b1;
            end
            if (w_pop) r_head <= ~r_head;
            r_occ <= w_occ_nxt;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_state  <= S_IDLE;
            r_remain <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_busy <= 1'b1;
                        if (bus.len != '0) begin
                            r_remain <= bus.len;
                            r_state  <= S_RUN;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_remain <= '0;
                        r_state  <= S_FLUSH;
                    end else if (w_rinc) begin
                        r_remain <= r_remain - 1'b1;
                        if (r_remain == LSIZE'(1)) r_state <= S_FLUSH;
                    end
                end
                // Completion fires the cycle after the last word leaves.
                S_FLUSH: begin
                    if (w_occ_nxt == 2'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_read_drainer.sv
// Directed/randomized bench for fifo_read_drainer with a queue-based
// FIFO model and an expected-output scoreboard.
module tb_fifo_read_drainer;
    logic rclk;
    logic rrst_n;

    fifo_read_drainer_if #(.DSIZE(8), .LSIZE(8), .CSIZE(16)) bus ();

    fifo_read_drainer #(.DSIZE(8), .LSIZE(8), .CSIZE(16)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    int errors = 0;
    int checks = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int mcount;
    int cyc;
    int n_rinc, n_acc, n_done;
    int first_rinc, last_rinc, first_valid, last_acc, done_cyc;
    logic p_hold;
    logic [7:0] p_data;
    logic s_busy, s_done, s_rinc;
    logic [7:0] w0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_scn();
        n_rinc = 0; n_acc = 0; n_done = 0;
        first_rinc = -1; last_rinc = -1; first_valid = -1;
        last_acc = -1; done_cyc = -1;
        p_hold = 1'b0;
    endtask

    task automatic drive_fifo();
        bus.rempty = (fq.size() == 0);
        bus.rdata  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    task automatic step();
        drive_fifo();
        #1;
        s_busy = bus.busy;
        s_done = bus.done;
        s_rinc = bus.rinc;
        if (p_hold) chk("hold_stable", bus.m_data, p_data);
        chk("m_valid", bus.m_valid, exp_q.size() != 0);
        chk("count", bus.count, mcount & 32'hFFFF);
        if (bus.m_valid && bus.m_ready) begin
            chk("order", bus.m_data, (exp_q.size() != 0) ? exp_q[0] : 8'hxx);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            n_acc++;
            last_acc = cyc;
        end
        if (bus.rinc) begin
            chk("no_underflow", bus.rempty, 1'b0);
            if (fq.size() != 0) exp_q.push_back(fq.pop_front());
            mcount++;
            n_rinc++;
            if (first_rinc < 0) first_rinc = cyc;
            last_rinc = cyc;
        end
        if (bus.m_valid && first_valid < 0) first_valid = cyc;
        if (bus.done) begin
            n_done++;
            done_cyc = cyc;
        end
        p_hold = bus.m_valid && !bus.m_ready;
        p_data = bus.m_data;
        @(posedge rclk);
        @(negedge rclk);
        cyc++;
        bus.start = 1'b0;
    endtask

    task automatic run_until_done(input int max);
        int d0;
        d0 = n_done;
        for (int i = 0; i < max; i++) begin
            if (n_done > d0) break;
            step();
        end
        chk("done_seen", n_done - d0, 1);
    endtask

    task automatic do_reset();
        rrst_n = 1'b0;
        @(negedge rclk);
        @(negedge rclk);
        rrst_n = 1'b1;
        exp_q.delete();
        mcount = 0;
        clr_scn();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) fq.push_back(8'($urandom));
    endtask

    initial begin
        cyc = 0;
        mcount = 0;
        rrst_n = 1'b0;
        bus.start = 1'b0;
        bus.len = '0;
        bus.abort = 1'b0;
        bus.m_ready = 1'b0;
        drive_fifo();
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_valid", bus.m_valid, 1'b0);
        chk("rst_data", bus.m_data, 8'h00);
        chk("rst_count", bus.count, 16'h0000);
        chk("rst_rinc", bus.rinc, 1'b0);
        @(negedge rclk);

        // basic drain, full throughput
        do_reset();
        fill(4);
        bus.m_ready = 1'b1;
        bus.len = 8'd4;
        bus.start = 1'b1;
        run_until_done(30);
        chk("s1_rinc_n", n_rinc, 4);
        chk("s1_rinc_b2b", last_rinc - first_rinc, 3);
        chk("s1_latency", first_valid - first_rinc, 1);
        chk("s1_done_t", done_cyc - last_acc, 1);
        chk("s1_acc", n_acc, 4);
        chk("s1_count", bus.count, 16'd4);
        step();
        chk("s1_idle", s_busy, 1'b0);

        // sparse FIFO writes, random backpressure
        do_reset();
        bus.len = 8'd3;
        bus.start = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 3 || i == 9 || i == 10) fill(1);
            bus.m_ready = 1'($urandom_range(0, 1));
            step();
            if (n_done != 0) break;
        end
        chk("s2_done", n_done, 1);
        chk("s2_acc", n_acc, 3);
        chk("s2_rinc", n_rinc, 3);
        chk("s2_count", bus.count, 16'd3);

        // backpressure with a full FIFO
        do_reset();
        fq.delete();
        fill(8);
        w0 = fq[0];
        bus.m_ready = 1'b0;
        bus.len = 8'd5;
        bus.start = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("s3_bp_rinc", n_rinc, 2);
        chk("s3_bp_valid", bus.m_valid, 1'b1);
        chk("s3_bp_head", bus.m_data, w0);
        bus.m_ready = 1'b1;
        run_until_done(40);
        chk("s3_acc", n_acc, 5);
        chk("s3_count", bus.count, 16'd5);
        chk("s3_fifo_left", fq.size(), 3);

        // zero length command
        clr_scn();
        bus.len = 8'd0;
        bus.start = 1'b1;
        step();
        step();
        chk("s4_busy", s_busy, 1'b1);
        chk("s4_done", s_done, 1'b1);
        chk("s4_rinc", s_rinc, 1'b0);
        step();
        chk("s4_busy_off", s_busy, 1'b0);
        chk("s4_done_off", s_done, 1'b0);
        chk("s4_no_pop", n_rinc, 0);

        // abort after the second pop
        do_reset();
        fq.delete();
        fill(8);
        bus.m_ready = 1'b1;
        bus.len = 8'd6;
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (n_rinc >= 2) break;
            step();
        end
        bus.abort = 1'b1;
        step();
        chk("s5_abort_rinc", s_rinc, 1'b0);
        bus.abort = 1'b0;
        run_until_done(20);
        chk("s5_rinc", n_rinc, 2);
        chk("s5_acc", n_acc, 2);
        chk("s5_count", bus.count, 16'd2);
        chk("s5_fifo_left", fq.size(), 6);

        // reset in RUN with a full buffer
        do_reset();
        bus.m_ready = 1'b0;
        bus.len = 8'd4;
        bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (n_rinc >= 2) break;
            step();
        end
        chk("s6_pre_valid", bus.m_valid, 1'b1);
        rrst_n = 1'b0;
        #1;
        chk("s6_valid", bus.m_valid, 1'b0);
        chk("s6_rinc", bus.rinc, 1'b0);
        chk("s6_busy", bus.busy, 1'b0);
        chk("s6_done", bus.done, 1'b0);
        chk("s6_count", bus.count, 16'd0);
        @(negedge rclk);
        rrst_n = 1'b1;
        exp_q.delete();
        mcount = 0;
        clr_scn();
        bus.m_ready = 1'b1;
        bus.len = 8'd1;
        bus.start = 1'b1;
        run_until_done(20);
        chk("s6_rinc_n", n_rinc, 1);
        chk("s6_acc", n_acc, 1);
        chk("s6_count1", bus.count, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
